rp_8bit_trace: RTL and testbench

Instruction-trace capture stage for the rp_8bit core.
- Observes the program-memory fetch bus and assembles each executed fetch into one 16-bit or 32-bit instruction record tagged with its word address.
- Buffers records in a small FIFO and presents them on a valid/ready stream.
- The consumer is the trace logger, which passes trc_code[15:0] to the disassembler.

---
 rtl/rp_8bit_trace_pkg.sv | 17 +
 rtl/rp_8bit_trace_if.sv | 19 +
 rtl/rp_8bit_trace_fifo.sv | 44 ++++
 rtl/rp_8bit_trace.sv | 69 ++++++
 tb/tb_rp_8bit_trace.sv | 124 ++++++++++++
 5 files changed

// File: rtl/rp_8bit_trace_pkg.sv
// rp_8bit_trace_pkg: shared types, two-word opcode masks and decode helper for the trace stage
package rp_8bit_trace_pkg;
  localparam int TRC_PAW = 16;
  localparam logic [15:0] LDS_MASK = 16'hFC0F;
  localparam logic [15:0] LDS_VAL  = 16'h9000;
  localparam logic [15:0] JMP_MASK = 16'hFE0C;
  localparam logic [15:0] JMP_VAL  = 16'h940C;
  typedef enum logic {IDLE, WAIT2} state_t;
  typedef struct packed {
    logic [TRC_PAW-1:0] pc;
    logic               len;
    logic [31:0]        code;
  } trace_t;
  function automatic logic is_two_word(bit [15:0] ins);
    return ((ins & LDS_MASK) == LDS_VAL) || ((ins & JMP_MASK) == JMP_VAL);
  endfunction
endpackage

// File: rtl/rp_8bit_trace_if.sv
// rp_8bit_trace_if: fetch bus, trace stream and status signals of the trace stage
interface rp_8bit_trace_if #(parameter int PAW = 16, parameter int DEPTH = 8, parameter int CW = 16);
  logic                     bus_vld;
  logic [PAW-1:0]           bus_adr;
  logic [15:0]              bus_ins;
  logic                     flush;
  logic                     trc_vld;
  logic                     trc_rdy;
  logic [PAW-1:0]           trc_pc;
  logic                     trc_len;
  logic [31:0]              trc_code;
  logic [$clog2(DEPTH):0]   sts_lvl;
  logic [CW-1:0]            sts_drp;
  logic [CW-1:0]            sts_err;
  modport master (output bus_vld, bus_adr, bus_ins, flush, trc_rdy,
                  input trc_vld, trc_pc, trc_len, trc_code, sts_lvl, sts_drp, sts_err);
  modport slave  (input bus_vld, bus_adr, bus_ins, flush, trc_rdy,
                  output trc_vld, trc_pc, trc_len, trc_code, sts_lvl, sts_drp, sts_err);
endinterface

// File: rtl/rp_8bit_trace_fifo.sv
// rp_8bit_trace_fifo: show-ahead FIFO of trace records; head is zero while empty
module rp_8bit_trace_fifo
  import rp_8bit_trace_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push_i,
  input  trace_t  dat_i,
  output logic    full_o,
  input  logic    pop_i,
  output logic    empty_o,
  output trace_t  dat_o,
  output logic [AW:0] lvl_o
);
  trace_t        mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          acc, pop_ok;
  always_comb begin
    empty_o = cnt_q == '0;
    full_o  = cnt_q == (AW+1)'(DEPTH);
    pop_ok  = pop_i && !empty_o;
    acc     = push_i && (!full_o || pop_ok);
    cnt_d   = cnt_q + (AW+1)'(acc) - (AW+1)'(pop_ok);
    dat_o   = empty_o ? '0 : mem_q[rd_q];
    lvl_o   = cnt_q;
  end
  always_ff @(posedge clk)
    if (acc) mem_q[wr_q] <= dat_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= acc ? wr_q + AW'(1) : wr_q;
      rd_q  <= pop_ok ? rd_q + AW'(1) : rd_q;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/rp_8bit_trace.sv
// rp_8bit_trace: assembles fetch beats into 16/32-bit instruction records and queues them for the trace logger
module rp_8bit_trace
  import rp_8bit_trace_pkg::*;
#(
  parameter int PAW   = TRC_PAW,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input logic clk,
  input logic rst,
  rp_8bit_trace_if.slave trc
);
  state_t         state_q, state_d;
  logic [PAW-1:0] adr_q, adr_d;
  logic [15:0]    ins_q, ins_d;
  logic [CW-1:0]  drp_q, drp_d, err_q, err_d;
  logic           proc, cont, brk, fresh, two, push, pop, full, empty, drop;
  trace_t         rec, head;
  always_comb begin
    proc    = trc.bus_vld && !trc.flush;
    cont    = state_q == WAIT2 && proc && trc.bus_adr == adr_q + PAW'(1);
    brk     = state_q == WAIT2 && proc && !cont;
    fresh   = proc && !cont;
    two     = is_two_word(trc.bus_ins);
    push    = cont || (fresh && !two);
    pop     = !empty && trc.trc_rdy;
    drop    = push && full && !pop;
    rec.pc   = TRC_PAW'(cont ? adr_q : trc.bus_adr);
    rec.len  = cont;
    rec.code = cont ? {trc.bus_ins, ins_q} : {16'h0, trc.bus_ins};
    state_d = (trc.flush || cont || (fresh && !two)) ? IDLE : (fresh && two) ? WAIT2 : state_q;
    adr_d   = (fresh && two) ? trc.bus_adr : adr_q;
    ins_d   = (fresh && two) ? trc.bus_ins : ins_q;
    drp_d   = drp_q + CW'(drop && drp_q != '1);
    err_d   = err_q + CW'(brk && err_q != '1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      adr_q   <= '0;
      ins_q   <= '0;
      drp_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      ins_q   <= ins_d;
      drp_q   <= drp_d;
      err_q   <= err_d;
    end
  end
  rp_8bit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .dat_i  (rec),
    .full_o (full),
    .pop_i  (pop),
    .empty_o(empty),
    .dat_o  (head),
    .lvl_o  (trc.sts_lvl)
  );
  assign trc.trc_vld  = !empty;
  assign trc.trc_pc   = PAW'(head.pc);
  assign trc.trc_len  = head.len;
  assign trc.trc_code = head.code;
  assign trc.sts_drp  = drp_q;
  assign trc.sts_err  = err_q;
endmodule

// File: tb/tb_rp_8bit_trace.sv
// tb_rp_8bit_trace: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_rp_8bit_trace;
  import rp_8bit_trace_pkg::*;
  logic clk = 0;
  logic rst = 1;
  int   n_chk = 0;
  int   n_fail = 0;
  trace_t sb[$];
  rp_8bit_trace_if #(.PAW(16), .DEPTH(8), .CW(16)) tif();
  rp_8bit_trace #(.PAW(16), .DEPTH(8), .CW(16)) dut (.clk(clk), .rst(rst), .trc(tif.slave));
  always #5 clk = ~clk;
  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction
  function automatic void expect_rec(logic [15:0] pc, logic len, logic [31:0] code);
    trace_t t;
    t.pc = pc;
    t.len = len;
    t.code = code;
    sb.push_back(t);
  endfunction
  always @(negedge clk) begin
    if (!rst && tif.trc_vld && tif.trc_rdy) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rec: got pc=%0h code=%0h expected none", tif.trc_pc, tif.trc_code);
      end else begin
        trace_t e;
        e = sb.pop_front();
        chk("rec_pc", 64'(tif.trc_pc), 64'(e.pc));
        chk("rec_len", 64'(tif.trc_len), 64'(e.len));
        chk("rec_code", 64'(tif.trc_code), 64'(e.code));
      end
    end
  end
  task automatic beat(logic [15:0] adr, logic [15:0] ins, logic fl = 1'b0);
    tif.bus_vld = 1;
    tif.bus_adr = adr;
    tif.bus_ins = ins;
    tif.flush = fl;
    @(posedge clk);
    #1;
    tif.bus_vld = 0;
    tif.flush = 0;
  endtask
  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    tif.bus_vld = 0;
    tif.bus_adr = 0;
    tif.bus_ins = 0;
    tif.flush = 0;
    tif.trc_rdy = 1;
    for (int i = 0; i < 2; i++) begin
      tif.bus_vld = ~tif.bus_vld;
      tif.bus_adr = 16'h0100;
      tif.bus_ins = 16'h0C01;
      @(posedge clk);
      #1;
    end
    tif.bus_vld = 0;
    rst = 0;
    chk("rst_vld", 64'(tif.trc_vld), 0);
    chk("rst_pc", 64'(tif.trc_pc), 0);
    chk("rst_len", 64'(tif.trc_len), 0);
    chk("rst_code", 64'(tif.trc_code), 0);
    chk("rst_lvl", 64'(tif.sts_lvl), 0);
    chk("rst_drp", 64'(tif.sts_drp), 0);
    chk("rst_err", 64'(tif.sts_err), 0);
    expect_rec(16'h0010, 0, 32'h00000C01);
    beat(16'h0010, 16'h0C01);
    chk("lat1_vld", 64'(tif.trc_vld), 1);
    idle(2);
    beat(16'h0020, 16'h940C);
    chk("jmp_first_novld", 64'(tif.trc_vld), 0);
    expect_rec(16'h0020, 1, 32'h1234940C);
    beat(16'h0021, 16'h1234);
    idle(2);
    beat(16'h0030, 16'h9100);
    expect_rec(16'h0040, 0, 32'h00000000);
    beat(16'h0040, 16'h0000);
    chk("broken_err", 64'(tif.sts_err), 1);
    idle(2);
    beat(16'h0050, 16'h940E);
    beat(16'h0051, 16'h1111, 1'b1);
    chk("flush_novld", 64'(tif.trc_vld), 0);
    chk("flush_err", 64'(tif.sts_err), 1);
    expect_rec(16'h0060, 0, 32'h00000000);
    beat(16'h0060, 16'h0000);
    idle(3);
    tif.trc_rdy = 0;
    for (int i = 0; i < 10; i++) begin
      if (i < 8) expect_rec(16'h0100 + 16'(i), 0, 32'h1 + 32'(i));
      beat(16'h0100 + 16'(i), 16'h1 + 16'(i));
    end
    chk("full_lvl", 64'(tif.sts_lvl), 8);
    chk("full_drp", 64'(tif.sts_drp), 2);
    tif.trc_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      expect_rec(16'h0200 + 16'(i), 0, 32'h0200 + 32'(i));
      beat(16'h0200 + 16'(i), 16'h0200 + 16'(i));
    end
    chk("pushpop_lvl", 64'(tif.sts_lvl), 8);
    chk("pushpop_drp", 64'(tif.sts_drp), 2);
    idle(10);
    chk("drained_lvl", 64'(tif.sts_lvl), 0);
    beat(16'hFFFF, 16'h9100);
    expect_rec(16'hFFFF, 1, 32'hABCD9100);
    beat(16'h0000, 16'hABCD);
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
    #1;
    chk("wrap_err", 64'(tif.sts_err), 1);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
